// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM stages), the unified-memory arbiter and the memory.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface unified_mem_arbiter_if #(
  parameter int MEM_ADDR_W = 10
);
  logic                  if_req;
  logic [63:0]           if_addr;
  logic [31:0]           if_rdata;
  logic                  if_valid;
  logic                  d_req;
  logic                  d_we;
  logic [63:0]           d_addr;
  logic [63:0]           d_wdata;
  logic [63:0]           d_rdata;
  logic                  d_valid;
  logic                  stall_if;
  logic                  stall_mem;
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [63:0]           mem_wdata;
  logic                  mem_ack;
  logic [63:0]           mem_rdata;
  logic                  err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, data first with a
// streak limiter against fetch starvation. Define MEM_ARB_TIMEOUT_EN to add the mem_ack watchdog.
module unified_mem_arbiter #(
  parameter int MEM_ADDR_W   = 10,
  parameter int MAX_D_STREAK = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int STK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_r;
  logic [STK_W-1:0] streak_r;
  logic             hi_word_r;
  logic             pick_d_s;
  logic             timeout_s;
  logic             unused_addr_s;

  assign unused_addr_s = ^{bus.if_addr[63:MEM_ADDR_W], bus.d_addr[63:MEM_ADDR_W]};

  // Data wins unless fetch is waiting and data already used up its streak.
  always_comb begin
    pick_d_s = bus.d_req & (~bus.if_req | (streak_r < STK_W'(MAX_D_STREAK)));
  end

  // Stalls are gated by reset so every output reads 0 while reset is held.
  assign bus.stall_if  = reset & bus.if_req & ~bus.if_valid;
  assign bus.stall_mem = reset & bus.d_req & ~bus.d_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WAIT_W-1:0] wait_r;

  // Watchdog fires on the last allowed GRANT cycle; a real ack in that cycle still wins.
  always_comb begin
    timeout_s = (wait_r == WAIT_W'(TIMEOUT - 1)) & ~bus.mem_ack;
  end
`else
  // Without the watchdog the arbiter waits for mem_ack indefinitely.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Arbiter FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      streak_r      <= '0;
      hi_word_r     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 64'd0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= 64'd0;
      bus.err       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_r        <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          bus.if_valid <= 1'b0;
          bus.d_valid  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_r       <= '0;
`endif
          if (pick_d_s) begin
            state_r       <= GRANT_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr[MEM_ADDR_W-1:0];
            bus.mem_wdata <= bus.d_wdata;
            // pick_d_s with if_req pending implies streak below the limit, so this saturates.
            streak_r      <= bus.if_req ? (streak_r + STK_W'(1)) : '0;
          end else if (bus.if_req) begin
            state_r       <= GRANT_I;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr[MEM_ADDR_W-1:0];
            bus.mem_wdata <= 64'd0;
            hi_word_r     <= bus.if_addr[2];
            streak_r      <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.mem_ack || timeout_s) begin
            state_r       <= RESP;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 64'd0;
            if (state_r == GRANT_I) begin
              bus.if_valid <= 1'b1;
              if (timeout_s) begin
                bus.if_rdata <= 32'd0;
              end else begin
                bus.if_rdata <= hi_word_r ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
              end
            end else begin
              bus.d_valid <= 1'b1;
              if (timeout_s) begin
                bus.d_rdata <= 64'd0;
              end else if (!bus.mem_we) begin
                bus.d_rdata <= bus.mem_rdata;
              end else begin
                bus.d_rdata <= bus.d_rdata;
              end
            end
            if (timeout_s) begin
              bus.err <= 1'b1;
            end else begin
              bus.err <= bus.err;
            end
          end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            wait_r <= wait_r + WAIT_W'(1);
`endif
            state_r <= state_r;
          end
        end
        RESP: begin
          bus.if_valid <= 1'b0;
          bus.d_valid  <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a small memory responder model.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.MEM_ADDR_W(10)) bus ();

  unified_mem_arbiter #(
    .MEM_ADDR_W  (10),
    .MAX_D_STREAK(2),
    .TIMEOUT     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_wait = 0;        // cycles of mem_req before ack; -1 = never ack
  logic [63:0] rdata_val = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits at least one cycle, then until a valid pulse or the budget runs out.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(bus.if_valid || bus.d_valid) && lat < budget);
  endtask

  // Memory responder: acks after ack_wait cycles of mem_req, drives junk otherwise.
  initial begin : mem_model
    int cnt;
    cnt           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    forever begin
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (bus.mem_req) begin
        if (ack_wait >= 0 && cnt == ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata_val;
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int lat;
    int total;
    int code;
    bit spurious;
    int exp_order [6];
    exp_order = '{1, 1, 2, 1, 1, 2};   // 1 = D grant, 2 = I grant

    reset       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = 64'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'd0;
    bus.d_wdata = 64'd0;
    repeat (3) tick();
    check_val("rst_mem_req", bus.mem_req, 1'b0);
    check_val("rst_valids", {bus.if_valid, bus.d_valid}, 2'b00);
    check_val("rst_err", bus.err, 1'b0);
    check_val("rst_rdata", {bus.if_rdata, bus.d_rdata[31:0]}, 64'd0);
    check_val("rst_mem_addr", bus.mem_addr, 10'd0);
    reset = 1'b1;
    tick();

    // Fetch with two wait cycles on the ack; upper word selected by if_addr[2].
    ack_wait    = 2;
    rdata_val   = 64'hAAAABBBB_CCCCDDDD;
    bus.if_addr = 64'h4;
    bus.if_req  = 1'b1;
    #1;
    check_val("t2_stall_if_early", bus.stall_if, 1'b1);
    tick();
    check_val("t2_grant", {bus.mem_req, bus.mem_we}, 2'b10);
    check_val("t2_mem_addr", bus.mem_addr, 10'h004);
    check_val("t2_stall_if_grant", bus.stall_if, 1'b1);
    wait_valid(20, lat);
    total = lat + 1;
    check_val("t2_latency", total, 4);
    check_val("t2_if_valid", bus.if_valid, 1'b1);
    check_val("t2_if_rdata", bus.if_rdata, 32'hAAAABBBB);
    check_val("t2_stall_if_resp", bus.stall_if, 1'b0);
    bus.if_req = 1'b0;
    tick();
    check_val("t2_single_pulse", bus.if_valid, 1'b0);

    // Both requesters held: streak limiter gives D,D,I,D,D,I.
    ack_wait    = 0;
    rdata_val   = 64'h11112222_33334444;
    bus.if_addr = 64'h8;
    bus.d_addr  = 64'h10;
    bus.d_we    = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_valid(10, lat);
      code = bus.d_valid ? 1 : (bus.if_valid ? 2 : 0);
      check_val($sformatf("t3_grant%0d", g), code, exp_order[g]);
      check_val($sformatf("t3_latency%0d", g), lat, (g == 0) ? 2 : 3);
      if (g == 0) check_val("t3_d_rdata", bus.d_rdata, 64'h11112222_33334444);
      if (g == 2) check_val("t3_if_rdata", bus.if_rdata, 32'h33334444);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();

    // Store: memory side sees the latched store, d_rdata keeps the last load value.
    ack_wait    = 1;
    rdata_val   = 64'hDEADBEEF_0BADF00D;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h18;
    bus.d_wdata = 64'h1234;
    bus.d_req   = 1'b1;
    tick();
    check_val("t4_grant", {bus.mem_req, bus.mem_we}, 2'b11);
    check_val("t4_mem_addr", bus.mem_addr, 10'h018);
    check_val("t4_mem_wdata", bus.mem_wdata, 64'h1234);
    tick();
    check_val("t4_mem_addr_stable", bus.mem_addr, 10'h018);
    wait_valid(20, lat);
    total = lat + 2;
    check_val("t4_latency", total, 3);
    check_val("t4_d_valid", bus.d_valid, 1'b1);
    check_val("t4_d_rdata_kept", bus.d_rdata, 64'h11112222_33334444);
    check_val("t4_resp_bus_idle", {bus.mem_req, bus.mem_we, bus.mem_addr}, 12'd0);
    bus.d_req = 1'b0;
    tick();
    check_val("t4_single_pulse", bus.d_valid, 1'b0);

    // Load with address bits above MEM_ADDR_W set: they wrap away.
    ack_wait    = 0;
    rdata_val   = 64'h01234567_89ABCDEF;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'hFFFF0000_00000418;
    bus.d_req   = 1'b1;
    tick();
    check_val("t4b_mem_addr_wrap", bus.mem_addr, 10'h018);
    wait_valid(10, lat);
    check_val("t4b_d_rdata", bus.d_rdata, 64'h01234567_89ABCDEF);
    bus.d_req = 1'b0;
    tick();

    // Reset in the middle of a GRANT_D: outputs clear at once, aborted access never responds.
    ack_wait   = -1;
    bus.d_addr = 64'h20;
    bus.d_req  = 1'b1;
    tick();
    check_val("t5_granted", bus.mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_val("t5_mem_req_async", bus.mem_req, 1'b0);
    check_val("t5_mem_addr_async", bus.mem_addr, 10'd0);
    check_val("t5_stall_mem_rst", bus.stall_mem, 1'b0);
    check_val("t5_d_rdata_rst", bus.d_rdata, 64'd0);
    bus.d_req = 1'b0;
    tick();
    reset    = 1'b1;
    spurious = 1'b0;
    repeat (6) begin
      tick();
      if (bus.d_valid || bus.if_valid || bus.mem_req) spurious = 1'b1;
    end
    check_val("t5_no_spurious", spurious, 1'b0);

    // After reset the FSM is back in IDLE and serves a normal load.
    ack_wait   = 0;
    rdata_val  = 64'h55556666_77778888;
    bus.d_addr = 64'h28;
    bus.d_req  = 1'b1;
    wait_valid(10, lat);
    check_val("t5_recover_latency", lat, 2);
    check_val("t5_recover_rdata", bus.d_rdata, 64'h55556666_77778888);
    bus.d_req = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: watchdog expires after 8 GRANT cycles, zero data, sticky err.
    ack_wait   = -1;
    bus.d_addr = 64'h30;
    bus.d_req  = 1'b1;
    tick();
    check_val("t6_err_before", bus.err, 1'b0);
    wait_valid(20, lat);
    total = lat + 1;
    check_val("t6_latency", total, 9);
    check_val("t6_d_valid", bus.d_valid, 1'b1);
    check_val("t6_err", bus.err, 1'b1);
    check_val("t6_d_rdata_zero", bus.d_rdata, 64'd0);
    check_val("t6_mem_req_dropped", bus.mem_req, 1'b0);
    bus.d_req = 1'b0;
    tick();
    ack_wait  = 0;
    rdata_val = 64'h99990000_AAAA1111;
    bus.d_req = 1'b1;
    wait_valid(10, lat);
    check_val("t6_next_rdata", bus.d_rdata, 64'h99990000_AAAA1111);
    check_val("t6_err_sticky", bus.err, 1'b1);
    bus.d_req = 1'b0;
    tick();
`else
    check_val("t6_err_tied", bus.err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
